alu_sched: RTL and testbench

Shared-ALU scheduler: arbitrates between two requesters, sequences one operation at a time through a single 8-bit ALU, and returns result plus status flags on a response channel. Single-cycle ops (pass/add/sub/logic) go through the combinational core. MUL and DIV are sequenced iteratively, one bit per cycle, over 8 cycles. Sits between the two issuing engines and the ALU datapath; it is the only master of the ALU core.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_core.sv | 45 ++++
 rtl/alu_sched.sv | 207 ++++++++++++++++++++
 tb/tb_alu_sched.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU scheduler: opcodes, FSM states and flag bit positions.
package alu_pkg;

  localparam logic [2:0] OpPass = 3'b000;
  localparam logic [2:0] OpAdd  = 3'b001;
  localparam logic [2:0] OpSub  = 3'b010;
  localparam logic [2:0] OpMul  = 3'b011;
  localparam logic [2:0] OpAnd  = 3'b100;
  localparam logic [2:0] OpOr   = 3'b101;
  localparam logic [2:0] OpXor  = 3'b110;
  localparam logic [2:0] OpDiv  = 3'b111;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StIter,
    StResp
  } state_e;

  // Bit positions inside flags_out = {V, C, N, Z}
  localparam int unsigned FlagZ = 0;
  localparam int unsigned FlagN = 1;
  localparam int unsigned FlagC = 2;
  localparam int unsigned FlagV = 3;

endpackage

// File: rtl/alu_core.sv
// Combinational single-cycle ALU: PASS/ADD/SUB/AND/OR/XOR with carry and signed overflow.
// For SUB, carry_o is the borrow (a < b). MUL/DIV opcodes yield zero here.
module alu_core #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_o,
  output logic             ovf_o
);
  import alu_pkg::*;

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  assign sum  = {1'b0, a_i} + {1'b0, b_i};
  assign diff = {1'b0, a_i} - {1'b0, b_i};

  // Opcode decode; flags stay low for everything but ADD/SUB
  always_comb begin
    result_o = '0;
    carry_o  = 1'b0;
    ovf_o    = 1'b0;
    case (op_i)
      OpPass: result_o = a_i;
      OpAdd: begin
        result_o = sum[WIDTH-1:0];
        carry_o  = sum[WIDTH];
        ovf_o    = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
      end
      OpSub: begin
        result_o = diff[WIDTH-1:0];
        carry_o  = diff[WIDTH];
        ovf_o    = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (diff[WIDTH-1] != a_i[WIDTH-1]);
      end
      OpAnd:   result_o = a_i & b_i;
      OpOr:    result_o = a_i | b_i;
      OpXor:   result_o = a_i ^ b_i;
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_sched.sv
// Two-requester scheduler for one shared ALU. Single-cycle ops pass through alu_core;
// MUL (shift-add) and DIV (restoring) iterate one bit per cycle, reusing the core's
// ADD and SUB paths. One op in flight; result held until the response handshake.
module alu_sched #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned ITER  = 8
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic [1:0]         req_valid_in,
  output logic [1:0]         req_ready_out,
  input  logic [WIDTH-1:0]   req0_a_in,
  input  logic [WIDTH-1:0]   req1_a_in,
  input  logic [WIDTH-1:0]   req0_b_in,
  input  logic [WIDTH-1:0]   req1_b_in,
  input  logic [2:0]         req0_op_in,
  input  logic [2:0]         req1_op_in,
  output logic               rsp_valid_out,
  input  logic               rsp_ready_in,
  output logic               rsp_id_out,
  output logic [2*WIDTH-1:0] results_out,
  output logic [3:0]         flags_out
);
  import alu_pkg::*;

  localparam int unsigned CntW = $clog2(ITER) + 1;

  state_e             state_q, state_d;
  logic               rr_q, rr_d;
  logic               id_q, id_d;
  logic [2:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   hi_q, hi_d;  // MUL accumulator / DIV remainder
  logic [WIDTH-1:0]   lo_q, lo_d;  // MUL multiplier / DIV quotient
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [2*WIDTH-1:0] res_q, res_d;
  logic [3:0]         flags_q, flags_d;

  logic               grant;
  logic               accept;
  logic [WIDTH-1:0]   sel_a, sel_b;
  logic [2:0]         sel_op;
  logic [2:0]         core_op;
  logic [WIDTH-1:0]   core_a, core_b, core_res;
  logic               core_c, core_v;

  // Arbitration: a lone requester wins outright, a tie goes to the round-robin pointer
  always_comb begin
    grant = rr_q;
    if (req_valid_in == 2'b01) begin
      grant = 1'b0;
    end else if (req_valid_in == 2'b10) begin
      grant = 1'b1;
    end
  end

  assign accept        = (state_q == StIdle) && (req_valid_in != 2'b00);
  assign req_ready_out = accept ? (grant ? 2'b10 : 2'b01) : 2'b00;
  assign sel_a         = grant ? req1_a_in : req0_a_in;
  assign sel_b         = grant ? req1_b_in : req0_b_in;
  assign sel_op        = grant ? req1_op_in : req0_op_in;

  // Core input steering: latched op in EXEC, partial sum / trial subtraction in ITER
  always_comb begin
    core_op = op_q;
    core_a  = a_q;
    core_b  = b_q;
    if (state_q == StIter) begin
      if (op_q == OpMul) begin
        core_op = OpAdd;
        core_a  = hi_q;
        core_b  = lo_q[0] ? a_q : '0;
      end else begin
        core_op = OpSub;
        core_a  = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
        core_b  = b_q;
      end
    end
  end

  alu_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .op_i     (core_op),
    .a_i      (core_a),
    .b_i      (core_b),
    .result_o (core_res),
    .carry_o  (core_c),
    .ovf_o    (core_v)
  );

  // FSM next state, operand latching, iteration datapath and result capture
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    id_d    = id_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    flags_d = flags_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          rr_d  = ~grant;
          id_d  = grant;
          op_d  = sel_op;
          a_d   = sel_a;
          b_d   = sel_b;
          cnt_d = '0;
          hi_d  = '0;
          if (sel_op == OpMul) begin
            lo_d    = sel_b;
            state_d = StIter;
          end else if (sel_op == OpDiv) begin
            lo_d    = sel_a;
            state_d = StIter;
          end else begin
            state_d = StExec;
          end
        end
      end
      StExec: begin
        res_d          = {{WIDTH{1'b0}}, core_res};
        flags_d        = '0;
        flags_d[FlagZ] = (core_res == '0);
        flags_d[FlagN] = core_res[WIDTH-1];
        flags_d[FlagC] = core_c;
        flags_d[FlagV] = core_v;
        state_d        = StResp;
      end
      StIter: begin
        if (op_q == OpMul) begin
          hi_d = {core_c, core_res[WIDTH-1:1]};
          lo_d = {core_res[0], lo_q[WIDTH-1:1]};
        end else if (hi_q[WIDTH-1] || !core_c) begin
          // Trial subtraction fits (a set shifted-out bit always fits)
          hi_d = core_res;
          lo_d = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
          hi_d = core_a;
          lo_d = {lo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(ITER - 1)) begin
          res_d   = {hi_d, lo_d};
          flags_d = '0;
          if (op_q == OpMul) begin
            flags_d[FlagZ] = ({hi_d, lo_d} == '0);
            flags_d[FlagN] = hi_d[WIDTH-1];
            flags_d[FlagV] = (hi_d != '0);
          end else begin
            flags_d[FlagZ] = (lo_d == '0);
            flags_d[FlagN] = lo_d[WIDTH-1];
            flags_d[FlagV] = (b_q == '0);
          end
          state_d = StResp;
        end
      end
      StResp: begin
        if (rsp_ready_in) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset discards any in-flight op
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= StIdle;
      rr_q    <= 1'b0;
      id_q    <= 1'b0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      id_q    <= id_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      flags_q <= flags_d;
    end
  end

  assign rsp_valid_out = (state_q == StResp);
  assign rsp_id_out    = id_q;
  assign results_out   = res_q;
  assign flags_out     = flags_q;

endmodule

// File: tb/tb_alu_sched.sv
// Bench for alu_sched: directed cases with literal expectations, backpressure, mid-op
// reset, tied arbitration, then random traffic against a transaction-level model.
module tb_alu_sched;

  logic       clk;
  logic       rst_n;
  logic [1:0] rq_v;
  logic [7:0] rq_a [2];
  logic [7:0] rq_b [2];
  logic [2:0] rq_op[2];
  logic       rsp_ready;
  logic [1:0] req_ready;
  logic       rsp_valid;
  logic       rsp_id;
  logic [15:0] results;
  logic [3:0] flags;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Model state
  logic [1:0]  acc_evt = 2'b00;
  bit          m_busy = 0;
  bit          m_rr = 0;
  int          m_due = 0;
  logic [15:0] m_res = '0;
  logic [3:0]  m_flg = '0;
  bit          m_id = 0;
  int          m_acc = 0, m_hs = 0, m_disc = 0, dut_hs = 0;
  bit          arb_on = 0;
  bit          gq[$];

  alu_sched #(
    .WIDTH (8),
    .ITER  (8)
  ) dut (
    .clk_in        (clk),
    .rst_n_in      (rst_n),
    .req_valid_in  (rq_v),
    .req_ready_out (req_ready),
    .req0_a_in     (rq_a[0]),
    .req1_a_in     (rq_a[1]),
    .req0_b_in     (rq_b[0]),
    .req1_b_in     (rq_b[1]),
    .req0_op_in    (rq_op[0]),
    .req1_op_in    (rq_op[1]),
    .rsp_valid_out (rsp_valid),
    .rsp_ready_in  (rsp_ready),
    .rsp_id_out    (rsp_id),
    .results_out   (results),
    .flags_out     (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference ALU from plain integer arithmetic; flags packed {V, C, N, Z}
  function automatic void ref_alu(input logic [7:0] a, input logic [7:0] b,
                                  input logic [2:0] op, output logic [15:0] r,
                                  output logic [3:0] f);
    int ua, ub, sa, sb, t;
    logic v, c, n, z;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    v = 1'b0;
    c = 1'b0;
    case (op)
      3'b000: t = ua;
      3'b001: begin
        t = ua + ub;
        c = (t > 255);
        v = (sa + sb > 127) || (sa + sb < -128);
        t = t % 256;
      end
      3'b010: begin
        t = (ua - ub + 256) % 256;
        c = (ua < ub);
        v = (sa - sb > 127) || (sa - sb < -128);
      end
      3'b011: begin
        t = ua * ub;
        v = (t > 255);
      end
      3'b100: t = int'(a & b);
      3'b101: t = int'(a | b);
      3'b110: t = int'(a ^ b);
      default: begin
        if (ub == 0) begin
          t = ua * 256 + 255;
          v = 1'b1;
        end else begin
          t = (ua % ub) * 256 + ua / ub;
        end
      end
    endcase
    r = 16'(t);
    if (op == 3'b011) begin
      z = (t == 0);
      n = r[15];
    end else begin
      z = (r[7:0] == 8'h00);
      n = r[7];
    end
    f = {v, c, n, z};
  endfunction

  // Transaction-level model and per-cycle comparison, sampled mid-cycle
  always @(negedge clk) begin : model
    logic [1:0] exp_rdy;
    bit         g;
    bit         exp_rv;
    acc_evt = 2'b00;
    if (!rst_n) begin
      if (m_busy) m_disc++;
      m_busy = 0;
      m_rr   = 0;
    end
    exp_rdy = 2'b00;
    g       = 0;
    if (!m_busy && rq_v != 2'b00) begin
      g       = (rq_v == 2'b11) ? m_rr : rq_v[1];
      exp_rdy = g ? 2'b10 : 2'b01;
    end
    exp_rv = m_busy && (cyc >= m_due);
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    check("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
    if (exp_rv) begin
      check("rsp_results", 32'(results), 32'(m_res));
      check("rsp_flags", 32'(flags), 32'(m_flg));
      check("rsp_id", 32'(rsp_id), 32'(m_id));
    end
    if (!rst_n) begin
      check("rst_results", 32'(results), 32'd0);
      check("rst_flags", 32'(flags), 32'd0);
      check("rst_id", 32'(rsp_id), 32'd0);
    end
    if (rsp_valid && rsp_ready && rst_n) dut_hs++;
    if (arb_on && req_ready != 2'b00) gq.push_back(req_ready[1]);
    if (rst_n) begin
      if (exp_rv && rsp_ready) begin
        m_busy = 0;
        m_hs++;
      end else if (!m_busy && rq_v != 2'b00) begin
        ref_alu(rq_a[g], rq_b[g], rq_op[g], m_res, m_flg);
        m_id   = g;
        m_busy = 1;
        m_rr   = ~g;
        m_due  = cyc + (((rq_op[g] == 3'b011) || (rq_op[g] == 3'b111)) ? 9 : 2);
        acc_evt[g] = 1'b1;
        m_acc++;
      end
    end
    cyc++;
  end

  function automatic logic [7:0] pick();
    case ($urandom_range(7, 0))
      0:       return 8'h00;
      1:       return 8'hFF;
      2:       return 8'h7F;
      3:       return 8'h80;
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic new_req(input int g);
    rq_op[g] = 3'($urandom_range(7, 0));
    rq_a[g]  = pick();
    rq_b[g]  = pick();
  endtask

  task automatic wait_accept(input int id);
    int n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!req_ready[id] && n < 40);
    check("accept_seen", 32'(req_ready[id]), 32'd1);
  endtask

  // Drop valid after accept, then measure latency and check the response against literals
  task automatic finish_op(input int id, input logic [15:0] er, input logic [3:0] ef,
                           input int elat);
    int n = 0;
    @(posedge clk);
    #1;
    rq_v[id] = 1'b0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!rsp_valid && n < 20);
    check("lit_latency", 32'(n), 32'(elat));
    check("lit_results", 32'(results), 32'(er));
    check("lit_flags", 32'(flags), 32'(ef));
    check("lit_id", 32'(rsp_id), 32'(id));
  endtask

  task automatic directed(input int id, input logic [7:0] a, input logic [7:0] b,
                          input logic [2:0] op, input logic [15:0] er, input logic [3:0] ef,
                          input int elat);
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    rq_a[id]  = a;
    rq_b[id]  = b;
    rq_op[id] = op;
    rq_v[id]  = 1'b1;
    wait_accept(id);
    finish_op(id, er, ef, elat);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    int n;
    rst_n     = 1'b0;
    rq_v      = 2'b00;
    rsp_ready = 1'b0;
    for (int g = 0; g < 2; g++) begin
      rq_a[g]  = '0;
      rq_b[g]  = '0;
      rq_op[g] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Directed ops with hand-computed results
    directed(0, 8'h7F, 8'h01, 3'b001, 16'h0080, 4'b1010, 2);
    directed(0, 8'h03, 8'h05, 3'b010, 16'h00FE, 4'b0110, 2);
    directed(0, 8'hFF, 8'hFF, 3'b011, 16'hFE01, 4'b1010, 9);
    directed(0, 8'h64, 8'h07, 3'b111, 16'h020E, 4'b0000, 9);
    directed(0, 8'h2A, 8'h00, 3'b111, 16'h2AFF, 4'b1010, 9);
    directed(1, 8'h80, 8'h80, 3'b001, 16'h0000, 4'b1101, 2);
    directed(1, 8'hA5, 8'hA5, 3'b110, 16'h0000, 4'b0001, 2);

    // Backpressure: response held 5 cycles while requester 1 waits
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    rq_a[0] = 8'hF0;
    rq_b[0] = 8'h3C;
    rq_op[0] = 3'b100;
    rq_v[0] = 1'b1;
    wait_accept(0);
    @(posedge clk);
    #1;
    rq_v[0] = 1'b0;
    rq_a[1] = 8'h01;
    rq_b[1] = 8'h02;
    rq_op[1] = 3'b001;
    rq_v[1] = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!rsp_valid && n < 20);
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", 32'(rsp_valid), 32'd1);
      check("stall_results", 32'(results), 32'h0030);
      check("stall_flags", 32'(flags), 32'd0);
      check("stall_id", 32'(rsp_id), 32'd0);
      check("stall_ready", 32'(req_ready), 32'd0);
      if (i < 4) begin
        @(negedge clk);
        #1;
      end
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    wait_accept(1);
    finish_op(1, 16'h0003, 4'b0000, 2);

    // Reset during the fourth ITER cycle of a MUL
    @(posedge clk);
    #1;
    rq_a[0] = 8'h12;
    rq_b[0] = 8'h34;
    rq_op[0] = 3'b011;
    rq_v[0] = 1'b1;
    wait_accept(0);
    @(posedge clk);
    #1;
    rq_v[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    check("mid_rst_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_results", 32'(results), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      #1;
      check("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
    end
    directed(0, 8'h10, 8'h20, 3'b001, 16'h0030, 4'b0000, 2);

    // Tied requests every cycle: grants must alternate
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    new_req(0);
    new_req(1);
    rq_v = 2'b11;
    arb_on = 1;
    repeat (80) begin
      @(posedge clk);
      #1;
      for (int g = 0; g < 2; g++) if (acc_evt[g]) new_req(g);
    end
    arb_on = 0;
    check("arb_grants", 32'(gq.size() >= 8), 32'd1);
    for (int i = 1; i < gq.size(); i++) begin
      check("arb_alternate", 32'(gq[i]), 32'(!gq[i-1]));
    end

    // Random traffic with random response backpressure
    repeat (1500) begin
      @(posedge clk);
      #1;
      for (int g = 0; g < 2; g++) begin
        if (acc_evt[g]) begin
          rq_v[g] = ($urandom_range(3, 0) != 0);
          if (rq_v[g]) new_req(g);
        end else if (!rq_v[g] && $urandom_range(2, 0) == 0) begin
          new_req(g);
          rq_v[g] = 1'b1;
        end
      end
      rsp_ready = ($urandom_range(3, 0) != 0);
    end

    // Drain: let pending requests be accepted, then collect all responses
    n = 0;
    while (rq_v != 2'b00 && n < 200) begin
      @(posedge clk);
      #1;
      rsp_ready = 1'b1;
      for (int g = 0; g < 2; g++) if (acc_evt[g]) rq_v[g] = 1'b0;
      n++;
    end
    check("drain_done", 32'(rq_v), 32'd0);
    repeat (20) @(posedge clk);
    #1;
    check("no_loss", 32'(dut_hs), 32'(m_acc - m_disc));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
